// File: rtl/pu_layer_sequencer.sv
// Runs a PU bank in rounds over one layer, start/ready handshake per PU, packing results.
// Round = ISSUE, ARM, WAIT (until every active PU has reported), STORE; no timeout on a missing PU ready.
module pu_layer_sequencer #(
  parameter  int NUM_NEURONS = 30,
  parameter  int NUM_PU      = 10,
  localparam int ROUNDS      = (NUM_NEURONS + NUM_PU - 1) / NUM_PU,
  localparam int RW          = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_PU-1:0]        pu_ready,
  input  logic [NUM_PU*8-1:0]      pu_out,
  output logic [NUM_PU-1:0]        pu_start,
  output logic [RW-1:0]            round_idx,
  output logic [NUM_NEURONS*8-1:0] layer_out,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_STORE, S_DONE
  } state_t;

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  state_t            state;
  logic [NUM_PU-1:0] ready_flags;
  logic [NUM_PU-1:0] active;
  logic [NUM_PU-1:0] seen;

  // A PU is active in a round only if it maps onto an existing neuron.
  function automatic logic [NUM_PU-1:0] active_mask(input logic [RW-1:0] r);
    logic [NUM_PU-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_PU; k++)
      m[k] = (int'(r) * NUM_PU + k) < NUM_NEURONS;
    return m;
  endfunction

  assign active = active_mask(round_idx);
  assign seen   = ready_flags | (pu_ready & active);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pu_start    <= '0;
      round_idx   <= '0;
      layer_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ready_flags <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ISSUE;
            round_idx <= '0;
            busy      <= 1'b1;
            pu_start  <= active_mask('0);
          end
        end
        S_ISSUE: begin
          pu_start    <= '0;
          ready_flags <= ~active;
          state       <= S_ARM;
        end
        // Ready from the previous round may still be high here; it is ignored.
        S_ARM: state <= S_WAIT;
        S_WAIT: begin
          ready_flags <= seen;
          for (int n = 0; n < NUM_NEURONS; n++) begin
            if (round_idx == RW'(n / NUM_PU) && pu_ready[n % NUM_PU])
              layer_out[n*8 +: 8] <= pu_out[(n % NUM_PU)*8 +: 8];
          end
          if (&seen) state <= S_STORE;
        end
        S_STORE: begin
          if (round_idx == LAST_ROUND) begin
            state     <= S_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            round_idx <= '0;
          end else begin
            state     <= S_ISSUE;
            round_idx <= round_idx + 1'b1;
            pu_start  <= active_mask(round_idx + 1'b1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_layer_sequencer.sv
// Directed bench for pu_layer_sequencer: a 30/10 instance and a 25/10 instance with behavioural PUs.
module tb_pu_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: 30 neurons, 10 PUs
  logic         start_a = 1'b0;
  logic [9:0]   rdy_a = '0;
  logic [79:0]  out_a = '0;
  logic [9:0]   pst_a;
  logic [1:0]   ridx_a;
  logic [239:0] lo_a;
  logic         busy_a, done_a;

  // Instance B: 25 neurons, 10 PUs
  logic         start_b = 1'b0;
  logic [9:0]   rdy_b = '0;
  logic [79:0]  out_b = '0;
  logic [9:0]   pst_b;
  logic [1:0]   ridx_b;
  logic [199:0] lo_b;
  logic         busy_b, done_b;

  pu_layer_sequencer #(.NUM_NEURONS(30), .NUM_PU(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pu_ready(rdy_a), .pu_out(out_a),
    .pu_start(pst_a), .round_idx(ridx_a), .layer_out(lo_a), .busy(busy_a), .done(done_a)
  );

  pu_layer_sequencer #(.NUM_NEURONS(25), .NUM_PU(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pu_ready(rdy_b), .pu_out(out_b),
    .pu_start(pst_b), .round_idx(ridx_b), .layer_out(lo_b), .busy(busy_b), .done(done_b)
  );

  // PU models: result = neuron index + offset, ready for one cycle lat cycles after pu_start.
  int         lat_a[10];
  int         cnt_a[10];
  logic [7:0] val_a[10];
  int         off_a = 0;
  bit         stale_a = 1'b0;
  bit         prev_pst_a = 1'b0;
  int         lat_b[10];
  int         cnt_b[10];
  logic [7:0] val_b[10];
  int         off_b = 0;

  initial begin
    for (int k = 0; k < 10; k++) begin
      lat_a[k] = 20; cnt_a[k] = 0; val_a[k] = '0;
      lat_b[k] = 20; cnt_b[k] = 0; val_b[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 10; k++) begin
      if (!rst) begin
        cnt_a[k] = 0; rdy_a[k] = 1'b0;
      end else if (pst_a[k]) begin
        cnt_a[k] = lat_a[k];
        val_a[k] = 8'(int'(ridx_a) * 10 + k + off_a);
        rdy_a[k] = 1'b0;
      end else if (cnt_a[k] > 0) begin
        cnt_a[k]--;
        rdy_a[k] = (cnt_a[k] == 0);
      end else begin
        rdy_a[k] = 1'b0;
      end
      // Stale mode: ready held high always, garbage on the bus during ISSUE/ARM.
      if (stale_a) begin
        rdy_a[k] = 1'b1;
        out_a[k*8 +: 8] = (pst_a != '0 || prev_pst_a) ? 8'hEE : val_a[k];
      end else begin
        out_a[k*8 +: 8] = rdy_a[k] ? val_a[k] : 8'hA5;
      end
    end
    prev_pst_a = (pst_a != '0);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 10; k++) begin
      if (!rst) begin
        cnt_b[k] = 0; rdy_b[k] = 1'b0;
      end else if (pst_b[k]) begin
        cnt_b[k] = lat_b[k];
        val_b[k] = 8'(int'(ridx_b) * 10 + k + off_b);
        rdy_b[k] = 1'b0;
      end else if (cnt_b[k] > 0) begin
        cnt_b[k]--;
        rdy_b[k] = (cnt_b[k] == 0);
      end else begin
        rdy_b[k] = 1'b0;
      end
      out_b[k*8 +: 8] = rdy_b[k] ? val_b[k] : 8'hA5;
    end
  end

  // Run record for instance A, cycle 1 = the ISSUE cycle after start is accepted.
  int           seq_code_a;
  int           npst_a;
  int           pcyc_a[8];
  int           ndone_a;
  int           done_cyc_a;
  int           busy_bad_a;
  logic [239:0] snap_a[$];

  task automatic run_a(input int budget, input int s1, input int s2);
    seq_code_a = 0; npst_a = 0; ndone_a = 0; done_cyc_a = -1; busy_bad_a = 0;
    snap_a.delete();
    for (int i = 0; i < 8; i++) pcyc_a[i] = -1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      snap_a.push_back(lo_a);
      if (pst_a != '0) begin
        seq_code_a = seq_code_a * 10 + int'(ridx_a) + 1;
        if (npst_a < 8) pcyc_a[npst_a] = c;
        npst_a++;
      end
      if (done_a) begin
        ndone_a++;
        if (done_cyc_a < 0) done_cyc_a = c;
      end else if (done_cyc_a < 0 && !busy_a) begin
        busy_bad_a++;
      end
      start_a = (c == s1 || c == s2);
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (pst_a !== '0 || ridx_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl_a: pst=%b ridx=%0d busy=%b done=%b, want all zero", pst_a, ridx_a, busy_a, done_a);
    end
    checks++;
    if (lo_a !== '0) begin
      failures++;
      $display("FAIL reset_layer_a: got %h, want 0", lo_a);
    end
    checks++;
    if (pst_b !== '0 || busy_b !== 1'b0 || done_b !== 1'b0 || lo_b !== '0) begin
      failures++;
      $display("FAIL reset_b: pst=%b busy=%b done=%b lo=%h, want all zero", pst_b, busy_b, done_b, lo_b);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [239:0] exp;
    for (int k = 0; k < 10; k++) lat_a[k] = 20;
    off_a = 5;
    for (int n = 0; n < 30; n++) exp[n*8 +: 8] = 8'(n + 5);
    run_a(100, -1, -1);
    checks++;
    if (seq_code_a !== 123) begin
      failures++;
      $display("FAIL basic_round_seq: code=%0d, want 123 (rounds 0,1,2)", seq_code_a);
    end
    checks++;
    if (pcyc_a[1] !== 23 || pcyc_a[2] !== 45) begin
      failures++;
      $display("FAIL basic_issue_cycles: %0d,%0d, want 23,45", pcyc_a[1], pcyc_a[2]);
    end
    checks++;
    if (ndone_a !== 1 || done_cyc_a !== 67) begin
      failures++;
      $display("FAIL basic_done: count=%0d cycle=%0d, want 1 at 67", ndone_a, done_cyc_a);
    end
    checks++;
    if (busy_bad_a !== 0) begin
      failures++;
      $display("FAIL basic_busy: low for %0d cycles before done, want 0", busy_bad_a);
    end
    checks++;
    if (lo_a !== exp) begin
      failures++;
      $display("FAIL basic_layer: got %h want %h", lo_a, exp);
    end
  endtask

  task automatic test_partial_round();
    logic [199:0] exp;
    logic [9:0]   pst_r2;
    int           npst, nd, dc;
    off_b = 5; pst_r2 = '0; npst = 0; nd = 0; dc = -1;
    for (int n = 0; n < 25; n++) exp[n*8 +: 8] = 8'(n + 5);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (pst_b != '0) begin
        npst++;
        if (ridx_b == 2'd2) pst_r2 = pst_b;
      end
      if (done_b) begin
        nd++;
        if (dc < 0) dc = c;
      end
      @(negedge clk);
    end
    checks++;
    if (pst_r2 !== 10'b0000011111 || npst !== 3) begin
      failures++;
      $display("FAIL partial_pu_start: round2=%b rounds=%0d, want 0000011111 and 3", pst_r2, npst);
    end
    checks++;
    if (nd !== 1 || dc !== 67) begin
      failures++;
      $display("FAIL partial_done: count=%0d cycle=%0d, want 1 at 67", nd, dc);
    end
    checks++;
    if (lo_b !== exp) begin
      failures++;
      $display("FAIL partial_layer: got %h want %h", lo_b, exp);
    end
  endtask

  task automatic test_skewed_ready();
    logic [239:0] exp;
    for (int k = 0; k < 10; k++) lat_a[k] = 12;
    lat_a[3] = 5; lat_a[7] = 40;
    off_a = 100;
    for (int n = 0; n < 30; n++) exp[n*8 +: 8] = 8'(n + 100);
    run_a(160, -1, -1);
    checks++;
    if (snap_a[6][3*8 +: 8] !== 8'd103 || snap_a[6][7*8 +: 8] !== 8'd12) begin
      failures++;
      $display("FAIL skew_early_capture: byte3=%0d byte7=%0d, want 103 and 12",
               snap_a[6][3*8 +: 8], snap_a[6][7*8 +: 8]);
    end
    checks++;
    if (snap_a[40][0 +: 8] !== 8'd100 || snap_a[40][7*8 +: 8] !== 8'd12) begin
      failures++;
      $display("FAIL skew_before_slow: byte0=%0d byte7=%0d, want 100 and 12",
               snap_a[40][0 +: 8], snap_a[40][7*8 +: 8]);
    end
    checks++;
    if (pcyc_a[1] !== 43 || done_cyc_a !== 127) begin
      failures++;
      $display("FAIL skew_no_early_advance: round1 issue=%0d done=%0d, want 43 and 127", pcyc_a[1], done_cyc_a);
    end
    checks++;
    if (lo_a !== exp) begin
      failures++;
      $display("FAIL skew_layer: got %h want %h", lo_a, exp);
    end
  endtask

  task automatic test_stale_ready();
    logic [239:0] exp;
    off_a = 200;
    stale_a = 1'b1;
    for (int n = 0; n < 30; n++) exp[n*8 +: 8] = 8'(n + 200);
    run_a(40, -1, -1);
    stale_a = 1'b0;
    checks++;
    if (pcyc_a[1] !== 5 || pcyc_a[2] !== 9 || done_cyc_a !== 13 || ndone_a !== 1) begin
      failures++;
      $display("FAIL stale_timing: issues=%0d,%0d done=%0d x%0d, want 5,9 done=13 x1",
               pcyc_a[1], pcyc_a[2], done_cyc_a, ndone_a);
    end
    checks++;
    if (lo_a !== exp) begin
      failures++;
      $display("FAIL stale_layer: got %h want %h", lo_a, exp);
    end
  endtask

  task automatic test_start_while_busy();
    logic [239:0] exp;
    for (int k = 0; k < 10; k++) lat_a[k] = 20;
    off_a = 30;
    for (int n = 0; n < 30; n++) exp[n*8 +: 8] = 8'(n + 30);
    run_a(110, 10, 50);
    checks++;
    if (seq_code_a !== 123 || npst_a !== 3) begin
      failures++;
      $display("FAIL busy_start_seq: code=%0d issues=%0d, want 123 and 3", seq_code_a, npst_a);
    end
    checks++;
    if (ndone_a !== 1 || done_cyc_a !== 67) begin
      failures++;
      $display("FAIL busy_start_done: count=%0d cycle=%0d, want 1 at 67", ndone_a, done_cyc_a);
    end
    checks++;
    if (lo_a !== exp) begin
      failures++;
      $display("FAIL busy_start_layer: got %h want %h", lo_a, exp);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [239:0] exp;
    int           c;
    for (int k = 0; k < 10; k++) lat_a[k] = 20;
    off_a = 60;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    c = 1;
    while (c < 30) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (ridx_a !== 2'd1 || busy_a !== 1'b1 || lo_a[0 +: 8] !== 8'd60) begin
      failures++;
      $display("FAIL midreset_pre: ridx=%0d busy=%b byte0=%0d, want 1,1,60", ridx_a, busy_a, lo_a[0 +: 8]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (pst_a !== '0 || ridx_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0 || lo_a !== '0) begin
      failures++;
      $display("FAIL midreset_async: pst=%b ridx=%0d busy=%b done=%b lo=%h, want all zero",
               pst_a, ridx_a, busy_a, done_a, lo_a);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    off_a = 70;
    for (int n = 0; n < 30; n++) exp[n*8 +: 8] = 8'(n + 70);
    run_a(100, -1, -1);
    checks++;
    if (seq_code_a !== 123 || ndone_a !== 1 || done_cyc_a !== 67) begin
      failures++;
      $display("FAIL midreset_rerun: code=%0d done=%0d at %0d, want 123, 1 at 67", seq_code_a, ndone_a, done_cyc_a);
    end
    checks++;
    if (lo_a !== exp) begin
      failures++;
      $display("FAIL midreset_layer: got %h want %h", lo_a, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skewed_ready();
    test_partial_round();
    test_stale_ready();
    test_start_while_busy();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
